mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_if.sv | 11 +
 rtl/mem_wb_stage.sv | 74 +++++++
 tb/tb_mem_wb_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: data-memory request/acknowledge bus between the MEM stage and memory.
interface mem_wb_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage access FSM plus MEM/WB pipeline register.
module mem_wb_stage (
  input  logic                  clk,
  input  logic                  rst,
  mem_wb_stage_if.master        mem,
  input  logic                  WB_ENin,
  input  logic [1:0]            MEM_Signal,
  input  logic [4:0]            Dest,
  input  logic [31:0]           ALU_Res,
  input  logic [31:0]           ST_Val,
  output logic                  freeze,
  output logic                  WB_EN,
  output logic [4:0]            WB_Dest,
  output logic [31:0]           WB_Data
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state_q;
  logic        req_q, we_q, wb_en_q;
  logic [31:0] addr_q, wdata_q, ld_q, wb_data_q, wb_data_d;
  logic [4:0]  wb_dest_q;
  logic        mem_op;
  assign mem_op    = |MEM_Signal;
  assign freeze    = mem_op & (state_q != DONE);
  assign wb_data_d = MEM_Signal[1] ? ld_q : ALU_Res;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign WB_EN   = wb_en_q;
  assign WB_Dest = wb_dest_q;
  assign WB_Data = wb_data_q;
  // Reads win over writes when both MEM_Signal bits are set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (mem_op) begin
          state_q <= ACCESS;
          req_q   <= 1'b1;
          we_q    <= ~MEM_Signal[1];
          addr_q  <= {ALU_Res[31:2], 2'b00};
          wdata_q <= ST_Val;
        end
        ACCESS: if (mem.mem_ack) begin
          state_q <= DONE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          ld_q    <= mem.mem_rdata;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // A frozen cycle inserts a bubble so a stalled instruction writes back once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q   <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
    end else if (freeze) begin
      wb_en_q <= 1'b0;
    end else begin
      wb_en_q   <= WB_ENin;
      wb_dest_q <= Dest;
      wb_data_q <= wb_data_d;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage write-back stream and memory bus.
module tb_mem_wb_stage;
  typedef struct {logic [4:0] d; logic [31:0] v;} wb_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WB_ENin = 1'b0;
  logic [1:0]  MEM_Signal = 2'b00;
  logic [4:0]  Dest = '0;
  logic [31:0] ALU_Res = '0;
  logic [31:0] ST_Val = '0;
  logic        freeze, WB_EN;
  logic [4:0]  WB_Dest;
  logic [31:0] WB_Data;
  logic [7:0]  fz = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  wb_t         sb[$];
  mem_wb_stage_if bus();
  mem_wb_stage dut (
    .clk(clk), .rst(rst), .mem(bus), .WB_ENin(WB_ENin), .MEM_Signal(MEM_Signal),
    .Dest(Dest), .ALU_Res(ALU_Res), .ST_Val(ST_Val), .freeze(freeze),
    .WB_EN(WB_EN), .WB_Dest(WB_Dest), .WB_Data(WB_Data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    fz = {fz[6:0], freeze};
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    WB_ENin = 1'b0;
    MEM_Signal = 2'b00;
  endtask
  always @(negedge clk) begin
    if (rst && WB_EN) begin
      if (sb.size() == 0) chk("unexp_wb", 32'd1, 32'd0);
      else begin
        wb_t e;
        e = sb.pop_front();
        chk("sb_dest", {27'd0, WB_Dest}, {27'd0, e.d});
        chk("sb_data", WB_Data, e.v);
      end
    end
  end
  task automatic alu_op(input logic en, input logic [4:0] d, input logic [31:0] res);
    WB_ENin = en; MEM_Signal = 2'b00; Dest = d; ALU_Res = res;
    #1 chk("alu_freeze", {31'd0, freeze}, 32'd0);
    if (en) sb.push_back('{d, res});
    tick;
    chk("alu_wben", {31'd0, WB_EN}, {31'd0, en});
    idle_inputs;
  endtask
  task automatic mem_op(input logic en, input logic [1:0] sig, input logic [4:0] d,
                        input logic [31:0] res, input logic [31:0] st, input int n,
                        input logic [31:0] rdata);
    logic [31:0] ea;
    ea = {res[31:2], 2'b00};
    WB_ENin = en; MEM_Signal = sig; Dest = d; ALU_Res = res; ST_Val = st;
    if (en) sb.push_back('{d, sig[1] ? rdata : res});
    #1 chk("mem_freeze_idle", {31'd0, freeze}, 32'd1);
    tick;
    for (int k = 1; k <= n; k++) begin
      chk("acc_req", {31'd0, bus.mem_req}, 32'd1);
      chk("acc_we", {31'd0, bus.mem_we}, {31'd0, sig == 2'b01});
      chk("acc_addr", bus.mem_addr, ea);
      chk("acc_wdata", bus.mem_wdata, st);
      chk("stall_wben", {31'd0, WB_EN}, 32'd0);
      if (k == n) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rdata;
      end
      tick;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
    end
    chk("done_freeze", {31'd0, freeze}, 32'd0);
    chk("done_req", {31'd0, bus.mem_req}, 32'd0);
    tick;
    if (en && sig[1]) chk("ld_data", WB_Data, rdata);
    idle_inputs;
  endtask
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    MEM_Signal = 2'b10;
    #2 rst = 1'b0;
    #1;
    chk("rst_freeze_memop", {31'd0, freeze}, 32'd1);
    MEM_Signal = 2'b00;
    #1;
    chk("rst_freeze_idle", {31'd0, freeze}, 32'd0);
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wben", {31'd0, WB_EN}, 32'd0);
    chk("rst_wbdata", WB_Data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    alu_op(1'b1, 5'd5, 32'h1234);
    chk("alu_dest", {27'd0, WB_Dest}, 32'd5);
    chk("alu_data", WB_Data, 32'h1234);
    alu_op(1'b1, 5'd0, 32'hCAFE_0001);
    fz = '0;
    mem_op(1'b1, 2'b10, 5'd7, 32'h0000_040A, 32'h0, 2, 32'hDEAD_BEEF);
    chk("ld_freeze_pattern", {28'd0, fz[3:0]}, 32'b1110);
    mem_op(1'b0, 2'b01, 5'd3, 32'h0000_1003, 32'hA5A5_A5A5, 1, 32'h0);
    tick;
    chk("st_no_wb", {31'd0, WB_EN}, 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
    tick;
    bus.mem_ack = 1'b0;
    chk("spur_req", {31'd0, bus.mem_req}, 32'd0);
    chk("spur_wben", {31'd0, WB_EN}, 32'd0);
    mem_op(1'b1, 2'b11, 5'd9, 32'h0000_2000, 32'h5555_0000, 1, 32'h0BAD_F00D);
    fz = '0;
    mem_op(1'b1, 2'b10, 5'd10, 32'h0000_0100, 32'h0, 1, 32'h1000_0001);
    mem_op(1'b1, 2'b10, 5'd11, 32'h0000_0204, 32'h0, 1, 32'h2000_0002);
    chk("b2b_freeze_pattern", {26'd0, fz[5:0]}, 32'b110110);
    WB_ENin = 1'b1; MEM_Signal = 2'b10; Dest = 5'd12; ALU_Res = 32'h0000_0300;
    tick;
    chk("mid_req", {31'd0, bus.mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("mid_rst_wben", {31'd0, WB_EN}, 32'd0);
    idle_inputs;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    rst = 1'b1;
    tick;
    bus.mem_ack = 1'b1;
    tick;
    bus.mem_ack = 1'b0;
    tick;
    chk("post_rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("post_rst_wben", {31'd0, WB_EN}, 32'd0);
    alu_op(1'b1, 5'd31, 32'hFFFF_FFFF);
    tick;
    tick;
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
